i2c_fifo: RTL and testbench



---
 rtl/i2c_fifo.sv | 112 +++++++++++
 tb/tb_i2c_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_fifo.sv
// Byte FIFO shared by the TX and RX paths of the I2C block.
// First-word-fall-through head, registered count, sticky overflow/underflow flags.
module i2c_fifo #(
    parameter int DATA_WIDTH        = 8,
    parameter int DEPTH             = 8,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         clear,
    input  logic                         clear_errors,
    input  logic                         write_enable,
    input  logic [DATA_WIDTH-1:0]        write_data,
    input  logic                         read_enable,
    output logic [DATA_WIDTH-1:0]        read_data,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  popOk;
    logic                  pushOk;

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_C);
    assign almost_full = (count_q >= AF_C);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign read_data   = empty ? '0 : mem_q[rptr_q];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign popOk  = read_enable && !empty && !clear;
    assign pushOk = write_enable && (!full || popOk) && !clear;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clear) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (pushOk) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (popOk) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({pushOk, popOk})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            // A fresh error in the same cycle beats clear_errors.
            if (clear_errors) begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
            if (write_enable && !pushOk) begin
                overflow_d = 1'b1;
            end
            if (read_enable && !popOk) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wptr_q] <= write_data;
        end
    end

endmodule

// File: tb/tb_i2c_fifo.sv
// Directed self-checking bench for i2c_fifo with the default 8x8 configuration.
// Inputs change and outputs are sampled 1ns after each rising clock edge.
module tb_i2c_fifo;

   logic       clk;
   logic       n_rst;
   logic       clear;
   logic       clear_errors;
   logic       write_enable;
   logic [7:0] write_data;
   logic       read_enable;
   logic [7:0] read_data;
   logic       empty;
   logic       full;
   logic       almost_full;
   logic [3:0] count;
   logic       overflow;
   logic       underflow;

   int checkCount;
   int failCount;

   i2c_fifo #(
      .DATA_WIDTH(8),
      .DEPTH(8),
      .ALMOST_FULL_LEVEL(7)
   ) dut (
      .clk(clk),
      .n_rst(n_rst),
      .clear(clear),
      .clear_errors(clear_errors),
      .write_enable(write_enable),
      .write_data(write_data),
      .read_enable(read_enable),
      .read_data(read_data),
      .empty(empty),
      .full(full),
      .almost_full(almost_full),
      .count(count),
      .overflow(overflow),
      .underflow(underflow)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compares one observed value with its expected value and logs mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one clock cycle of requests, then returns all requests to idle
   task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic re,
                                input logic clr, input logic clrErr);
      write_enable = we;
      write_data   = wd;
      read_enable  = re;
      clear        = clr;
      clear_errors = clrErr;
      @(posedge clk);
      #1;
      write_enable = 1'b0;
      read_enable  = 1'b0;
      clear        = 1'b0;
      clear_errors = 1'b0;
   endtask

   // Directed scenarios with hand-computed expectations
   initial begin
      checkCount   = 0;
      failCount    = 0;
      n_rst        = 1'b0;
      clear        = 1'b0;
      clear_errors = 1'b0;
      write_enable = 1'b0;
      write_data   = 8'h00;
      read_enable  = 1'b0;
      #12;
      checkOutput("reset empty", 32'(empty), 32'd1);
      checkOutput("reset count", 32'(count), 32'd0);
      checkOutput("reset full", 32'(full), 32'd0);
      checkOutput("reset almost_full", 32'(almost_full), 32'd0);
      checkOutput("reset overflow", 32'(overflow), 32'd0);
      checkOutput("reset underflow", 32'(underflow), 32'd0);
      checkOutput("reset read_data", 32'(read_data), 32'h00);
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] basic push/pop");
      applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      checkOutput("fwft head 11", 32'(read_data), 32'h11);
      applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      checkOutput("count 3", 32'(count), 32'd3);
      checkOutput("not empty", 32'(empty), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("pop1 head 22", 32'(read_data), 32'h22);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("pop2 head 33", 32'(read_data), 32'h33);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("pop3 empty", 32'(empty), 32'd1);
      checkOutput("pop3 read_data 0", 32'(read_data), 32'h00);

      $display("[TB] fill and overflow");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
         checkOutput("fill almost_full", 32'(almost_full), (i + 1 >= 7) ? 32'd1 : 32'd0);
         checkOutput("fill full", 32'(full), (i + 1 == 8) ? 32'd1 : 32'd0);
      end
      applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      checkOutput("overflow set", 32'(overflow), 32'd1);
      checkOutput("overflow count 8", 32'(count), 32'd8);
      checkOutput("overflow head 00", 32'(read_data), 32'h00);

      $display("[TB] push and pop while full");
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checkOutput("clear_errors overflow", 32'(overflow), 32'd0);
      applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
      checkOutput("full pushpop count", 32'(count), 32'd8);
      checkOutput("full pushpop head 01", 32'(read_data), 32'h01);
      checkOutput("full pushpop no overflow", 32'(overflow), 32'd0);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("drain head 55", 32'(read_data), 32'h55);
      checkOutput("drain count 1", 32'(count), 32'd1);
      checkOutput("drain no overflow", 32'(overflow), 32'd0);

      $display("[TB] wrap-around");
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      checkOutput("clear empty", 32'(empty), 32'd1);
      applyStimulus(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("wrap head 0", 32'(read_data), 32'd0);
      for (int i = 1; i < 20; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
         checkOutput("wrap head", 32'(read_data), 32'(i));
         checkOutput("wrap count", 32'(count), 32'd1);
      end
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("wrap final empty", 32'(empty), 32'd1);

      $display("[TB] underflow");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("underflow set", 32'(underflow), 32'd1);
      checkOutput("underflow count 0", 32'(count), 32'd0);
      applyStimulus(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
      checkOutput("empty pushpop count", 32'(count), 32'd1);
      checkOutput("empty pushpop head", 32'(read_data), 32'h3C);
      checkOutput("empty pushpop underflow", 32'(underflow), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      checkOutput("clear_errors underflow", 32'(underflow), 32'd0);
      checkOutput("clear_errors count", 32'(count), 32'd1);

      $display("[TB] clear and async reset");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("five stored", 32'(count), 32'd5);
      checkOutput("five overflow", 32'(overflow), 32'd1);
      checkOutput("five head", 32'(read_data), 32'h42);
      applyStimulus(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
      checkOutput("clear count", 32'(count), 32'd0);
      checkOutput("clear empty", 32'(empty), 32'd1);
      checkOutput("clear overflow", 32'(overflow), 32'd0);
      applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
      checkOutput("prereset count", 32'(count), 32'd2);
      #2;
      n_rst = 1'b0;
      #1;
      checkOutput("async reset count", 32'(count), 32'd0);
      checkOutput("async reset empty", 32'(empty), 32'd1);
      checkOutput("async reset read_data", 32'(read_data), 32'h00);
      #3;
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post reset empty", 32'(empty), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
